// File: rtl/surf_dac_loader.sv
// surf_dac_loader: 32 x 16-bit threshold-DAC register file with a serial sweep engine.
// Local-bus writes land in the register file at any time, and readback is registered.
// An update strobe walks every channel out to NUM_CHIPS serial DACs. The DACs share
// SCLK and DIN, and each chip has its own active-low chip select.
module surf_dac_loader #(
  parameter int NUM_CHIPS   = 4,
  parameter int CH_PER_CHIP = 8,
  parameter int DATA_BITS   = 12,
  parameter int CLK_DIV     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 dac_wr_i,
  input  logic [4:0]           dac_waddr_i,
  input  logic [15:0]          dac_dat_i,
  input  logic [4:0]           dac_raddr_i,
  output logic [15:0]          dac_dat_o,
  input  logic                 dac_update_i,
  output logic                 dac_busy_o,
  output logic                 load_done_o,
  output logic                 dac_sclk_o,
  output logic                 dac_din_o,
  output logic [NUM_CHIPS-1:0] dac_ncs_o
);

  localparam int DEPTH      = NUM_CHIPS * CH_PER_CHIP;
  localparam int IDX_W      = 5;
  localparam int CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FRAME_BITS = 24;
  localparam int PAD        = 16 - DATA_BITS;
  localparam logic [15:0] DATA_MASK = 16'((32'd1 << DATA_BITS) - 32'd1);
  localparam logic [5:0]  LAST_HALF = 6'(2 * FRAME_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_GAP
  } state_t;

  logic [15:0]            mem_q [DEPTH];

  state_t                 state_q,   state_d;
  logic [IDX_W-1:0]       index_q,   index_d;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;
  logic [5:0]             half_q,    half_d;
  logic [FRAME_BITS-1:0]  shift_q,   shift_d;
  logic                   sclk_q,    sclk_d;
  logic                   din_q,     din_d;
  logic [NUM_CHIPS-1:0]   ncs_q,     ncs_d;
  logic                   busy_q,    busy_d;
  logic                   done_q,    done_d;
  logic                   pending_q, pending_d;
  logic [15:0]            dat_q,     dat_d;

  logic [15:0]            load_word;
  logic [15:0]            data_field;
  logic [3:0]             ch_field;
  logic [IDX_W-1:0]       chip_idx;
  logic [FRAME_BITS-1:0]  frame_w;
  logic                   cnt_done;
  logic                   last_index;

  // Register file write port; contents deliberately survive rst_i
  always_ff @(posedge clk_i) begin
    if (dac_wr_i) begin
      mem_q[dac_waddr_i] <= dac_dat_i;
    end
  end

  // Build the 24-bit DAC frame for the channel the sweep is currently loading
  always_comb begin
    load_word  = mem_q[index_q];
    data_field = (load_word & DATA_MASK) << PAD;
    ch_field   = 4'(index_q % IDX_W'(CH_PER_CHIP));
    chip_idx   = index_q / IDX_W'(CH_PER_CHIP);
    frame_w    = {4'b0011, ch_field, data_field};
    cnt_done   = (cnt_q == CNT_W'(CLK_DIV - 1));
    last_index = (index_q == IDX_W'(DEPTH - 1));
  end

  // Sweep sequencer next-state logic; every output is registered from these values
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    shift_d   = shift_q;
    sclk_d    = sclk_q;
    din_d     = din_q;
    ncs_d     = ncs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pending_d = pending_q;
    dat_d     = mem_q[dac_raddr_i];

    if (state_q != ST_IDLE && dac_update_i) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (dac_update_i) begin
          state_d = ST_LOAD;
          index_d = '0;
          busy_d  = 1'b1;
        end
      end

      ST_LOAD: begin
        shift_d = frame_w;
        din_d   = frame_w[FRAME_BITS-1];
        ncs_d   = ~(NUM_CHIPS'(1) << chip_idx);
        cnt_d   = '0;
        state_d = ST_CS_SETUP;
      end

      ST_CS_SETUP: begin
        if (cnt_done) begin
          cnt_d   = '0;
          half_d  = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        if (cnt_done) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            shift_d = shift_q << 1;
            din_d   = shift_q[FRAME_BITS-2];
          end
          if (half_q == LAST_HALF) begin
            state_d = ST_CS_HOLD;
          end else begin
            half_d = half_q + 6'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_CS_HOLD: begin
        if (cnt_done) begin
          cnt_d   = '0;
          ncs_d   = '1;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (cnt_done) begin
          cnt_d = '0;
          if (!last_index) begin
            index_d = index_q + IDX_W'(1);
            state_d = ST_LOAD;
          end else if (pending_q || dac_update_i) begin
            pending_d = 1'b0;
            done_d    = 1'b1;
            index_d   = '0;
            state_d   = ST_LOAD;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        ncs_d   = '1;
        sclk_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      cnt_q     <= '0;
      half_q    <= '0;
      shift_q   <= '0;
      sclk_q    <= 1'b0;
      din_q     <= 1'b0;
      ncs_q     <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      shift_q   <= shift_d;
      sclk_q    <= sclk_d;
      din_q     <= din_d;
      ncs_q     <= ncs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pending_q <= pending_d;
      dat_q     <= dat_d;
    end
  end

  assign dac_dat_o   = dat_q;
  assign dac_busy_o  = busy_q;
  assign load_done_o = done_q;
  assign dac_sclk_o  = sclk_q;
  assign dac_din_o   = din_q;
  assign dac_ncs_o   = ncs_q;

endmodule

// File: tb/tb_surf_dac_loader.sv
// Bench for surf_dac_loader. The directed stimulus pushes the expected frames,
// busy-run lengths and load_done busy levels into queues. A free-running monitor
// captures the serial bus and pops those queues as the DUT produces each event.
module tb_surf_dac_loader;

  localparam int CLK_DIV    = 2;
  localparam int FRAME_CLKS = 51 * CLK_DIV + 1;
  localparam int SWEEP_CLKS = 32 * FRAME_CLKS;

  typedef struct packed {
    logic [23:0] bits;
    logic [3:0]  ncs;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr = 1'b0;
  logic [4:0]  waddr = '0;
  logic [15:0] wdat = '0;
  logic [4:0]  raddr = '0;
  logic        upd = 1'b0;
  logic [15:0] dat_o;
  logic        busy;
  logic        done;
  logic        sclk;
  logic        din;
  logic [3:0]  ncs;

  int          n_cmp = 0;
  int          n_err = 0;
  int          frames_done = 0;
  logic [15:0] model_mem [32];

  frame_t      exp_frames [$];
  int          exp_busy_len [$];
  logic        exp_done_busy [$];

  surf_dac_loader #(
    .NUM_CHIPS(4), .CH_PER_CHIP(8), .DATA_BITS(12), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk_i(clk), .rst_i(rst), .dac_wr_i(wr), .dac_waddr_i(waddr),
    .dac_dat_i(wdat), .dac_raddr_i(raddr), .dac_dat_o(dat_o),
    .dac_update_i(upd), .dac_busy_o(busy), .load_done_o(done),
    .dac_sclk_o(sclk), .dac_din_o(din), .dac_ncs_o(ncs)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic report_fail(input string name);
    n_cmp++;
    n_err++;
    $display("[TB] FAIL %s: event seen but not expected / bound expired", name);
  endtask

  // One-cycle register-file write, mirrored into the bench model
  task automatic applyStimulus(input logic [4:0] addr, input logic [15:0] data);
    @(posedge clk); #1;
    wr = 1'b1; waddr = addr; wdat = data;
    @(posedge clk); #1;
    wr = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic pulse_update();
    @(posedge clk); #1; upd = 1'b1;
    @(posedge clk); #1; upd = 1'b0;
  endtask

  task automatic read_check(input logic [4:0] addr, input logic [15:0] want, input string name);
    @(posedge clk); #1; raddr = addr;
    @(posedge clk);
    @(negedge clk);
    checkOutput(name, 32'(dat_o), 32'(want));
  endtask

  function automatic frame_t frame_of(input int idx, input logic [15:0] word);
    frame_t f;
    logic [2:0] ch;
    ch     = 3'(idx % 8);
    f.bits = {4'b0011, 1'b0, ch, word[11:0], 4'b0000};
    f.ncs  = ~(4'b0001 << (idx / 8));
    return f;
  endfunction

  task automatic push_frames(input int count);
    for (int k = 0; k < count; k++) begin
      exp_frames.push_back(frame_of(k % 32, model_mem[k % 32]));
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3 * SWEEP_CLKS + 200; k++) begin
      @(negedge clk);
      if (!busy && exp_frames.size() == 0 && exp_busy_len.size() == 0 &&
          exp_done_busy.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      report_fail(name);
    end
  endtask

  task automatic wait_frames(input int target, input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20 * FRAME_CLKS; k++) begin
      @(negedge clk);
      if (frames_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      report_fail(name);
    end
  endtask

  // Serial-bus monitor and scoreboard comparator
  logic [23:0] cap_bits = '0;
  int          cap_n = 0;
  logic [3:0]  cap_ncs = 4'hF;
  logic        prev_sclk = 1'b0;
  logic [3:0]  prev_ncs = 4'hF;
  logic        prev_busy = 1'b0;
  int          busy_run = 0;

  always @(negedge clk) begin
    frame_t want;
    if (rst) begin
      cap_bits  = '0;
      cap_n     = 0;
      cap_ncs   = 4'hF;
      prev_sclk = 1'b0;
      prev_ncs  = 4'hF;
      prev_busy = 1'b0;
      busy_run  = 0;
    end else begin
      if (sclk && !prev_sclk) begin
        cap_bits = {cap_bits[22:0], din};
        cap_n++;
        cap_ncs = ncs;
      end
      if (ncs == 4'hF && prev_ncs != 4'hF) begin
        if (exp_frames.size() == 0) begin
          report_fail("frame_unexpected");
        end else begin
          want = exp_frames.pop_front();
          checkOutput("frame_bits", 32'(cap_bits), 32'(want.bits));
          checkOutput("frame_ncs", 32'(cap_ncs), 32'(want.ncs));
          checkOutput("frame_len", 32'(cap_n), 32'd24);
        end
        frames_done++;
        cap_n    = 0;
        cap_bits = '0;
      end
      if (busy) begin
        busy_run++;
      end
      if (!busy && prev_busy) begin
        if (exp_busy_len.size() == 0) begin
          report_fail("busy_unexpected");
        end else begin
          checkOutput("busy_len", 32'(busy_run), 32'(exp_busy_len.pop_front()));
        end
        busy_run = 0;
      end
      if (done) begin
        if (exp_done_busy.size() == 0) begin
          report_fail("load_done_unexpected");
        end else begin
          checkOutput("load_done_busy", 32'(busy), 32'(exp_done_busy.pop_front()));
        end
      end
      prev_sclk = sclk;
      prev_ncs  = ncs;
      prev_busy = busy;
    end
  end

  initial begin
    int base;
    bit ok;
    $display("[TB] start, CLK_DIV=%0d sweep=%0d clocks", CLK_DIV, SWEEP_CLKS);

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ncs", 32'(ncs), 32'hF);
    checkOutput("rst_sclk", 32'(sclk), 32'h0);
    checkOutput("rst_din", 32'(din), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_dat", 32'(dat_o), 32'h0);
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      applyStimulus(5'(i), 16'(i * 16'h0101));
    end

    // Test 1: readback and read-first collision
    applyStimulus(5'd5, 16'h0ABC);
    read_check(5'd5, 16'h0ABC, "rd_addr5");
    @(posedge clk); #1;
    wr = 1'b1; waddr = 5'd5; wdat = 16'h1234; raddr = 5'd5;
    @(posedge clk); #1;
    wr = 1'b0;
    model_mem[5] = 16'h1234;
    @(negedge clk);
    checkOutput("rd_collide_old", 32'(dat_o), 32'h0ABC);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rd_collide_new", 32'(dat_o), 32'h1234);
    read_check(5'd17, 16'h1111, "rd_addr17");
    applyStimulus(5'd5, 16'h0505);

    // Test 2: one full sweep
    push_frames(32);
    exp_busy_len.push_back(SWEEP_CLKS);
    exp_done_busy.push_back(1'b0);
    pulse_update();
    wait_idle("sweep1_timeout");

    // Test 3: two strobes during a sweep collapse into one extra sweep
    push_frames(64);
    exp_busy_len.push_back(2 * SWEEP_CLKS);
    exp_done_busy.push_back(1'b1);
    exp_done_busy.push_back(1'b0);
    pulse_update();
    repeat (100) @(posedge clk);
    pulse_update();
    repeat (300) @(posedge clk);
    pulse_update();
    wait_idle("sweep_pending_timeout");

    // Test 4: write to channel 31 while frame 3 is on the wire
    model_mem[31] = 16'h0FFF;
    push_frames(32);
    exp_busy_len.push_back(SWEEP_CLKS);
    exp_done_busy.push_back(1'b0);
    base = frames_done;
    pulse_update();
    wait_frames(base + 3, "frame3_timeout");
    applyStimulus(5'd31, 16'h0FFF);
    wait_idle("sweep_write_timeout");

    // Test 5: reset during frame 10 shift
    push_frames(10);
    base = frames_done;
    pulse_update();
    wait_frames(base + 10, "frame10_timeout");
    ok = 1'b0;
    for (int k = 0; k < 4 * FRAME_CLKS; k++) begin
      @(negedge clk);
      if (sclk) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) report_fail("frame10_sclk_timeout");
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_ncs", 32'(ncs), 32'hF);
    checkOutput("abort_sclk", 32'(sclk), 32'h0);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_done", 32'(done), 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    checkOutput("abort_frames_left", 32'(exp_frames.size()), 32'h0);
    read_check(5'd10, 16'h0A0A, "rd_after_rst10");
    read_check(5'd31, 16'h0FFF, "rd_after_rst31");
    push_frames(32);
    exp_busy_len.push_back(SWEEP_CLKS);
    exp_done_busy.push_back(1'b0);
    pulse_update();
    wait_idle("sweep_after_rst_timeout");

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
